// File: rtl/tdm_demux4_if.sv
// Slot-word lane and channel outputs of the 4-slot TDM receive demultiplexer.
interface tdm_demux4_if #(parameter int WIDTH = 8);
    logic [WIDTH-1:0] din;
    logic             din_valid;
    logic             sync;
    logic [WIDTH-1:0] z0, z1, z2, z3;
    logic [3:0]       zv;
    logic [1:0]       sel;
    logic             locked;
    logic             frame_done;
    logic             sync_err;

    modport master (
        output din, din_valid, sync,
        input  z0, z1, z2, z3, zv, sel, locked, frame_done, sync_err
    );

    modport slave (
        input  din, din_valid, sync,
        output z0, z1, z2, z3, zv, sel, locked, frame_done, sync_err
    );
endinterface

// File: rtl/tdm_demux4.sv
// 1:4 TDM receive demultiplexer: slot counting, channel routing, frame/sync flags.
// Optional TDM_DEMUX4_FRAME_LATCH_EN: publish all four channels together on frame_done.
module tdm_demux4 #(
    parameter int WIDTH = 8
) (
    input logic        clk,
    input logic        rst,
    tdm_demux4_if.slave bus
);
    typedef enum logic {HUNT, LOCKED} state_t;

    state_t                  state, state_nx;
    logic [1:0]              sel, sel_nx;
    logic [3:0]              wr;
    logic                    fd_nx, se_nx;
    logic [3:0][WIDTH-1:0]   z;
    logic [3:0]              zv;
    logic                    frame_done, sync_err;

    always_comb begin
        state_nx = state;
        sel_nx   = sel;
        wr       = 4'b0000;
        fd_nx    = 1'b0;
        se_nx    = 1'b0;
        if (bus.din_valid) begin
            case (state)
                HUNT: begin
                    if (bus.sync) begin
                        wr       = 4'b0001;
                        sel_nx   = 2'd1;
                        state_nx = LOCKED;
                    end
                end
                LOCKED: begin
                    if (bus.sync) begin
                        // Early sync aborts the partial frame and restarts at slot 0.
                        wr     = 4'b0001;
                        sel_nx = 2'd1;
                        se_nx  = (sel != 2'd0);
                    end else if (sel == 2'd0) begin
                        se_nx    = 1'b1;
                        sel_nx   = 2'd0;
                        state_nx = HUNT;
                    end else begin
                        wr     = 4'b0001 << sel;
                        sel_nx = sel + 2'd1;
                        // Any error restarts the frame, so reaching slot 3 implies a clean frame.
                        fd_nx  = (sel == 2'd3);
                    end
                end
                default: state_nx = HUNT;
            endcase
        end
    end

`ifdef TDM_DEMUX4_FRAME_LATCH_EN
    logic [2:0][WIDTH-1:0] sh;

    always_ff @(posedge clk) begin
        if (rst) begin
            sh <= '0;
            z  <= '0;
            zv <= 4'b0000;
        end else begin
            for (int k = 0; k < 3; k++)
                if (wr[k]) sh[k] <= bus.din;
            zv <= fd_nx ? 4'b1111 : 4'b0000;
            // Slot 3 is accepted on this same edge, so it comes straight from din.
            if (fd_nx) z <= {bus.din, sh[2], sh[1], sh[0]};
        end
    end
`else
    always_ff @(posedge clk) begin
        if (rst) begin
            z  <= '0;
            zv <= 4'b0000;
        end else begin
            for (int k = 0; k < 4; k++)
                if (wr[k]) z[k] <= bus.din;
            zv <= wr;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= HUNT;
            sel        <= 2'd0;
            frame_done <= 1'b0;
            sync_err   <= 1'b0;
        end else begin
            state      <= state_nx;
            sel        <= sel_nx;
            frame_done <= fd_nx;
            sync_err   <= se_nx;
        end
    end

    assign bus.z0         = z[0];
    assign bus.z1         = z[1];
    assign bus.z2         = z[2];
    assign bus.z3         = z[3];
    assign bus.zv         = zv;
    assign bus.sel        = sel;
    assign bus.locked     = (state == LOCKED);
    assign bus.frame_done = frame_done;
    assign bus.sync_err   = sync_err;
endmodule

// File: tb/tb_tdm_demux4.sv
// Directed self-checking bench for tdm_demux4 (WIDTH=8).
module tb_tdm_demux4;
`ifdef TDM_DEMUX4_FRAME_LATCH_EN
    localparam bit L = 1'b1;
`else
    localparam bit L = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    tdm_demux4_if #(.WIDTH(8)) bus ();

    tdm_demux4 #(.WIDTH(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    // {z0,z1,z2,z3,zv,sel,locked,frame_done,sync_err}
    logic [40:0] obs;
    assign obs = {bus.z0, bus.z1, bus.z2, bus.z3, bus.zv, bus.sel,
                  bus.locked, bus.frame_done, bus.sync_err};

    function automatic logic [40:0] e(input logic [7:0] a, b, c, d, input logic [3:0] v,
                                      input logic [1:0] s, input logic lk, fd, se);
        return {a, b, c, d, v, s, lk, fd, se};
    endfunction

    task automatic step(input logic [7:0] d, input logic v, input logic s);
        @(negedge clk);
        bus.din       = d;
        bus.din_valid = v;
        bus.sync      = s;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            if (i == 2) rst = 1'b0;
            step(8'h5A, 1'b0, 1'b1);
            checks++;
            if (obs !== 41'd0) begin
                errors++;
                $display("FAIL reset[%0d] got %h want %h", i, obs, 41'd0);
            end
        end
    endtask

    task automatic test_clean_frame;
        logic [7:0]  d[5] = '{8'hA0, 8'hB1, 8'hC2, 8'hD3, 8'h00};
        logic        v[5] = '{1, 1, 1, 1, 0};
        logic        s[5] = '{1, 0, 0, 0, 0};
        logic [40:0] x[5];
        x[0] = L ? e(0, 0, 0, 0, 0, 1, 1, 0, 0) : e(8'hA0, 0, 0, 0, 4'h1, 1, 1, 0, 0);
        x[1] = L ? e(0, 0, 0, 0, 0, 2, 1, 0, 0) : e(8'hA0, 8'hB1, 0, 0, 4'h2, 2, 1, 0, 0);
        x[2] = L ? e(0, 0, 0, 0, 0, 3, 1, 0, 0) : e(8'hA0, 8'hB1, 8'hC2, 0, 4'h4, 3, 1, 0, 0);
        x[3] = e(8'hA0, 8'hB1, 8'hC2, 8'hD3, L ? 4'hF : 4'h8, 0, 1, 1, 0);
        x[4] = e(8'hA0, 8'hB1, 8'hC2, 8'hD3, 4'h0, 0, 1, 0, 0);
        for (int i = 0; i < 5; i++) begin
            step(d[i], v[i], s[i]);
            checks++;
            if (obs !== x[i]) begin
                errors++;
                $display("FAIL clean_frame[%0d] got %h want %h", i, obs, x[i]);
            end
        end
    endtask

    task automatic test_gapped_frame;
        logic [7:0]  d[8] = '{8'hA0, 8'hFF, 8'hB1, 8'hFF, 8'hC2, 8'hFF, 8'hD3, 8'hFF};
        logic        v[8] = '{1, 0, 1, 0, 1, 0, 1, 0};
        logic        s[8] = '{1, 1, 0, 1, 0, 1, 0, 1};
        logic [40:0] x[8];
        rst = 1'b1;
        step(8'h00, 1'b0, 1'b0);
        rst = 1'b0;
        x[0] = L ? e(0, 0, 0, 0, 0, 1, 1, 0, 0) : e(8'hA0, 0, 0, 0, 4'h1, 1, 1, 0, 0);
        x[1] = L ? e(0, 0, 0, 0, 0, 1, 1, 0, 0) : e(8'hA0, 0, 0, 0, 4'h0, 1, 1, 0, 0);
        x[2] = L ? e(0, 0, 0, 0, 0, 2, 1, 0, 0) : e(8'hA0, 8'hB1, 0, 0, 4'h2, 2, 1, 0, 0);
        x[3] = L ? e(0, 0, 0, 0, 0, 2, 1, 0, 0) : e(8'hA0, 8'hB1, 0, 0, 4'h0, 2, 1, 0, 0);
        x[4] = L ? e(0, 0, 0, 0, 0, 3, 1, 0, 0) : e(8'hA0, 8'hB1, 8'hC2, 0, 4'h4, 3, 1, 0, 0);
        x[5] = L ? e(0, 0, 0, 0, 0, 3, 1, 0, 0) : e(8'hA0, 8'hB1, 8'hC2, 0, 4'h0, 3, 1, 0, 0);
        x[6] = e(8'hA0, 8'hB1, 8'hC2, 8'hD3, L ? 4'hF : 4'h8, 0, 1, 1, 0);
        x[7] = e(8'hA0, 8'hB1, 8'hC2, 8'hD3, 4'h0, 0, 1, 0, 0);
        for (int i = 0; i < 8; i++) begin
            step(d[i], v[i], s[i]);
            checks++;
            if (obs !== x[i]) begin
                errors++;
                $display("FAIL gapped_frame[%0d] got %h want %h", i, obs, x[i]);
            end
        end
    endtask

    // Starts locked at sel=0 with z = A0,B1,C2,D3.
    task automatic test_early_sync;
        logic [7:0]  d[7] = '{8'h11, 8'h22, 8'h33, 8'h00, 8'h44, 8'h45, 8'h46};
        logic        v[7] = '{1, 1, 1, 0, 1, 1, 1};
        logic        s[7] = '{1, 0, 1, 0, 0, 0, 0};
        logic [40:0] x[7];
        x[0] = L ? e(8'hA0, 8'hB1, 8'hC2, 8'hD3, 0, 1, 1, 0, 0) : e(8'h11, 8'hB1, 8'hC2, 8'hD3, 4'h1, 1, 1, 0, 0);
        x[1] = L ? e(8'hA0, 8'hB1, 8'hC2, 8'hD3, 0, 2, 1, 0, 0) : e(8'h11, 8'h22, 8'hC2, 8'hD3, 4'h2, 2, 1, 0, 0);
        x[2] = L ? e(8'hA0, 8'hB1, 8'hC2, 8'hD3, 0, 1, 1, 0, 1) : e(8'h33, 8'h22, 8'hC2, 8'hD3, 4'h1, 1, 1, 0, 1);
        x[3] = L ? e(8'hA0, 8'hB1, 8'hC2, 8'hD3, 0, 1, 1, 0, 0) : e(8'h33, 8'h22, 8'hC2, 8'hD3, 4'h0, 1, 1, 0, 0);
        x[4] = L ? e(8'hA0, 8'hB1, 8'hC2, 8'hD3, 0, 2, 1, 0, 0) : e(8'h33, 8'h44, 8'hC2, 8'hD3, 4'h2, 2, 1, 0, 0);
        x[5] = L ? e(8'hA0, 8'hB1, 8'hC2, 8'hD3, 0, 3, 1, 0, 0) : e(8'h33, 8'h44, 8'h45, 8'hD3, 4'h4, 3, 1, 0, 0);
        x[6] = e(8'h33, 8'h44, 8'h45, 8'h46, L ? 4'hF : 4'h8, 0, 1, 1, 0);
        for (int i = 0; i < 7; i++) begin
            step(d[i], v[i], s[i]);
            checks++;
            if (obs !== x[i]) begin
                errors++;
                $display("FAIL early_sync[%0d] got %h want %h", i, obs, x[i]);
            end
        end
    endtask

    // Starts locked at sel=0 after a clean frame with z = 33,44,45,46.
    task automatic test_loss_of_lock;
        logic [7:0]  d[4] = '{8'h55, 8'h56, 8'h00, 8'h66};
        logic        v[4] = '{1, 1, 0, 1};
        logic        s[4] = '{0, 0, 0, 1};
        logic [40:0] x[4];
        x[0] = e(8'h33, 8'h44, 8'h45, 8'h46, 4'h0, 0, 0, 0, 1);
        x[1] = e(8'h33, 8'h44, 8'h45, 8'h46, 4'h0, 0, 0, 0, 0);
        x[2] = e(8'h33, 8'h44, 8'h45, 8'h46, 4'h0, 0, 0, 0, 0);
        x[3] = L ? e(8'h33, 8'h44, 8'h45, 8'h46, 0, 1, 1, 0, 0) : e(8'h66, 8'h44, 8'h45, 8'h46, 4'h1, 1, 1, 0, 0);
        for (int i = 0; i < 4; i++) begin
            step(d[i], v[i], s[i]);
            checks++;
            if (obs !== x[i]) begin
                errors++;
                $display("FAIL loss_of_lock[%0d] got %h want %h", i, obs, x[i]);
            end
        end
    endtask

    task automatic test_reset_mid_frame;
        logic [7:0]  d[7] = '{8'h00, 8'h77, 8'h88, 8'hEE, 8'h99, 8'hAA, 8'h00};
        logic        v[7] = '{0, 1, 1, 1, 1, 0, 0};
        logic        s[7] = '{0, 1, 0, 0, 0, 1, 0};
        logic        r[7] = '{1, 0, 0, 1, 0, 0, 0};
        logic [40:0] x[7];
        x[0] = 41'd0;
        x[1] = L ? e(0, 0, 0, 0, 0, 1, 1, 0, 0) : e(8'h77, 0, 0, 0, 4'h1, 1, 1, 0, 0);
        x[2] = L ? e(0, 0, 0, 0, 0, 2, 1, 0, 0) : e(8'h77, 8'h88, 0, 0, 4'h2, 2, 1, 0, 0);
        x[3] = 41'd0;
        x[4] = 41'd0;
        x[5] = 41'd0;
        x[6] = 41'd0;
        for (int i = 0; i < 7; i++) begin
            rst = r[i];
            step(d[i], v[i], s[i]);
            checks++;
            if (obs !== x[i]) begin
                errors++;
                $display("FAIL reset_mid_frame[%0d] got %h want %h", i, obs, x[i]);
            end
        end
        rst = 1'b0;
    endtask

    initial begin
        bus.din       = '0;
        bus.din_valid = 1'b0;
        bus.sync      = 1'b0;
        test_reset();
        test_clean_frame();
        test_gapped_frame();
        test_early_sync();
        test_loss_of_lock();
        test_reset_mid_frame();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
